// File: rtl/gpio_p0_bus_sched.sv
// GPIO port 0 sequencer: arbitrates CPU bus reads against peripheral captures,
// then runs latch -> tristate drive -> turnaround for the granted transfer.
module gpio_p0_bus_sched #(
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_rd_req,
  input  logic periph_req,
  output logic gpio_en,
  output logic bus_tri_en,
  output logic periph_tri_en,
  output logic cpu_rd_ack,
  output logic periph_ack,
  output logic grant_id,
  output logic busy
);

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
      $error("gpio_p0_bus_sched: HOLD_CYCLES must be 1..15");
    end
    if (TURN_CYCLES < 0 || TURN_CYCLES > 15) begin : g_bad_turn
      $error("gpio_p0_bus_sched: TURN_CYCLES must be 0..15");
    end
  endgenerate

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES);
  localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t     r_state, w_nstate;
  logic [3:0] r_cnt, w_ncnt;
  logic       r_gid, w_ngid;
  logic       r_last, w_nlast;
  logic       w_req_g, w_end, w_arb;

  assign w_req_g = r_gid ? periph_req : cpu_rd_req;

  // The edge that closes a transfer also arbitrates, so a pending request is
  // latched with no dead IDLE cycle in between.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ngid   = r_gid;
    w_nlast  = r_last;
    w_end    = 1'b0;
    w_arb    = 1'b0;
    case (r_state)
      S_IDLE:  w_arb = 1'b1;
      S_LATCH: begin
        if (!w_req_g) begin
          w_end = 1'b1;
        end else begin
          w_nstate = S_DRIVE;
          w_ncnt   = HOLD_LD;
        end
      end
      S_DRIVE: begin
        if (!w_req_g || r_cnt == 4'd1) w_end = 1'b1;
        else                           w_ncnt = r_cnt - 4'd1;
      end
      S_TURN: begin
        if (r_cnt == 4'd1) begin
          w_nlast = r_gid;
          w_arb   = 1'b1;
        end else begin
          w_ncnt = r_cnt - 4'd1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase

    if (w_end) begin
      if (TURN_CYCLES == 0) begin
        w_nlast = r_gid;
        w_arb   = 1'b1;
      end else begin
        w_nstate = S_TURN;
        w_ncnt   = TURN_LD;
      end
    end

    if (w_arb) begin
      w_nstate = S_IDLE;
      if (cpu_rd_req || periph_req) begin
        w_nstate = S_LATCH;
        w_ngid   = (cpu_rd_req && periph_req) ? ~w_nlast : periph_req;
      end
    end
  end

  // Outputs decode the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_gid         <= 1'b0;
      r_last        <= 1'b1;
      gpio_en       <= 1'b0;
      bus_tri_en    <= 1'b0;
      periph_tri_en <= 1'b0;
      cpu_rd_ack    <= 1'b0;
      periph_ack    <= 1'b0;
      grant_id      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state       <= w_nstate;
      r_cnt         <= w_ncnt;
      r_gid         <= w_ngid;
      r_last        <= w_nlast;
      gpio_en       <= (w_nstate == S_LATCH);
      bus_tri_en    <= (w_nstate == S_DRIVE) && !w_ngid;
      periph_tri_en <= (w_nstate == S_DRIVE) &&  w_ngid;
      cpu_rd_ack    <= (w_nstate == S_DRIVE) && (w_ncnt == 4'd1) && !w_ngid;
      periph_ack    <= (w_nstate == S_DRIVE) && (w_ncnt == 4'd1) &&  w_ngid;
      grant_id      <= w_ngid;
      busy          <= (w_nstate != S_IDLE);
    end
  end

endmodule
